alu_core: RTL and testbench
===========================

// Module: alu_core
// PURPOSE
//  32-bit integer ALU for the single-cycle MIPS-lite datapath (addu/subu/ori/lui, beq compare).
//  Computes one of four ops on operands a/b selected by op.
//  Result and zero flag are registered on the rising edge of clk.
//  Sits between the register file / imm-extender (a, b) and the DM / writeback mux (aluout) and branch logic (zero).
// PARAMETERS
//  WIDTH      32   operand/result width in bits
// PORTS
//  clk       in   1      rising-edge clock; single clock domain
//  reset     in   1      synchronous, active-high reset
//  a         in   WIDTH  operand A (rs value)
//  b         in   WIDTH  operand B (rt value or extended immediate)
//  op        in   2      operation select (encoding below)
//  in_valid  in   1      qualifies a/b/op this cycle
//  zero      out  1      registered: 1 when registered aluout == 0
//  aluout    out  WIDTH  registered result
//  out_valid out  1      registered copy of in_valid
// BEHAVIOUR
//  - Clocking: one clock, clk; reset is synchronous and active-high, sampled on posedge clk.
//  - Reset values: aluout = 0, zero = 1 (consistent with aluout == 0), out_valid = 0.
//    Reset has priority over in_valid in the same cycle.
//    Reset mid-stream discards the in-flight result.
//  - op encoding:
//      2'b00 ADD -> a + b
//      2'b01 SUB -> a - b
//      2'b10 OR  -> a | b
//      2'b11 LUI -> {b[15:0], 16'b0}
//  - Arithmetic: modulo 2^WIDTH, two's complement.
//    No overflow/carry output, no exception; the carry-out is dropped (addu/subu semantics).
//  - Latency: exactly 1 cycle. Inputs sampled at edge N with in_valid=1 appear on aluout/zero/out_valid after edge N.
//  - in_valid=0 at an edge: aluout and zero hold their previous values; out_valid <= 0.
//  - No backpressure: a new op is accepted every cycle and the ALU is fully pipelined.
//  - zero is derived from the computed result, not from a==b directly.
//    For SUB, zero=1 iff a==b (beq).
//    For the other ops, zero=1 iff the result is 0.
//  - Boundaries:
//      ADD 32'hFFFFFFFF+1 wraps to 0 with zero=1.
//      SUB 0-1 gives 32'hFFFFFFFF with zero=0.
//      LUI ignores a and b[31:16].
//  - No X propagation from unused operand bits. Outputs are never X after reset.
// STRUCTURE
//  - Shared package alu_pkg holds:
//      localparams ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_OR=2'b10, ALU_LUI=2'b11
//      WIDTH default 32
//    Decoder/controller modules import the same constants.
//  - One natural sub-module: alu_comb. It is purely combinational: (a, b, op) -> (result, result_zero).
//  - alu_core wraps alu_comb with the output register stage and valid pipeline.
// TESTING
//  - Reset: reset=1 for 2 edges -> aluout=0, zero=1, out_valid=0.
//  - SUB equal: a=1, b=1, op=01, in_valid=1 -> next edge aluout=0, zero=1, out_valid=1.
//  - ADD wrap: a=32'hFFFFFFFF, b=1, op=00 -> aluout=0, zero=1.
//    Then a=5, b=7, op=00 -> aluout=12, zero=0.
//  - SUB negative: a=0, b=1, op=01 -> aluout=32'hFFFFFFFF, zero=0.
//  - OR/LUI: a=32'h00F0, b=32'h0F0F, op=10 -> aluout=32'h0FFF.
//    Then a=32'hDEAD, b=32'hABCD1234, op=11 -> aluout=32'h12340000.
//  - Hold/priority: in_valid=0 holds aluout and drops out_valid.
//    reset=1 together with in_valid=1 -> reset values win.
//  - Reference model: random a/b/op for 10k cycles, compared 1 cycle later.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcode constants and datapath width
package alu_pkg;

  localparam int WIDTH = 32;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_LUI = 2'b11;

endpackage

// File: rtl/alu_if.sv
// rtl/alu_if.sv - operand/result bundle between issue logic and the ALU
interface alu_if #(
  parameter int WIDTH = alu_pkg::WIDTH
);
  import alu_pkg::*;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             in_valid;
  logic             zero;
  logic [WIDTH-1:0] aluout;
  logic             out_valid;

  modport master (
    output a, b, op, in_valid,
    input  zero, aluout, out_valid
  );

  modport slave (
    input  a, b, op, in_valid,
    output zero, aluout, out_valid
  );

endinterface

// File: rtl/alu_comb.sv
// rtl/alu_comb.sv - combinational add/sub/or/lui datapath with zero detect
module alu_comb #(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             result_zero
);
  import alu_pkg::*;

  always_comb begin
    result = '0;
    unique case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_OR:  result = a | b;
      ALU_LUI: result = WIDTH'({b[15:0], 16'h0000});
      default: result = '0;
    endcase
  end

  // a - b is zero exactly when a == b, so beq reuses this flag
  assign result_zero = (result == '0);

endmodule

// File: rtl/alu_core.sv
// rtl/alu_core.sv - registered ALU stage: one-cycle latency, fully pipelined
module alu_core #(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic  clk,
  input  logic  reset,
  alu_if.slave  bus
);
  import alu_pkg::*;

  logic [WIDTH-1:0] result;
  logic             result_zero;
  logic [WIDTH-1:0] aluout_q;
  logic             zero_q;
  logic             valid_q;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .a           (bus.a),
    .b           (bus.b),
    .op          (bus.op),
    .result      (result),
    .result_zero (result_zero)
  );

  // Result and flag hold across idle cycles; only the valid bit tracks in_valid
  always_ff @(posedge clk) begin
    if (reset) begin
      aluout_q <= '0;
      zero_q   <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        aluout_q <= result;
        zero_q   <= result_zero;
      end
    end
  end

  assign bus.aluout    = aluout_q;
  assign bus.zero      = zero_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_alu_core.sv
// tb/tb_alu_core.sv - directed and random checks of alu_core against a behavioural model
module tb_alu_core;
  import alu_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  alu_if #(.WIDTH(32)) bus ();

  alu_core #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_result(logic [31:0] a, logic [31:0] b, logic [1:0] op);
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned x;
    ua = a;
    ub = b;
    case (op)
      2'd0:    x = (ua + ub) % 64'h1_0000_0000;
      2'd1:    x = (ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000;
      2'd2:    x = ua | ub;
      default: x = (ub % 65536) * 65536;
    endcase
    return x[31:0];
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30)
        $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endfunction

  // Model state: what the outputs must be after the most recent edge
  logic [31:0] m_out;
  logic        m_zero;
  logic        m_valid;
  bit          m_live;

  initial m_live = 1'b0;

  always @(posedge clk) begin
    if (reset === 1'b1) begin
      m_out   = 32'd0;
      m_zero  = 1'b1;
      m_valid = 1'b0;
      m_live  = 1'b1;
    end else if (m_live) begin
      m_valid = bus.in_valid;
      if (bus.in_valid) begin
        m_out  = model_result(bus.a, bus.b, bus.op);
        m_zero = (bus.op == 2'd1) ? (bus.a == bus.b) : (m_out == 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("model_aluout", bus.aluout, m_out);
      check("model_zero", {31'd0, bus.zero}, {31'd0, m_zero});
      check("model_out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
    end
  end

  task automatic apply(input logic r, input logic v, input logic [31:0] aa,
                       input logic [31:0] bb, input logic [1:0] o);
    @(negedge clk);
    reset        = r;
    bus.in_valid = v;
    bus.a        = aa;
    bus.b        = bb;
    bus.op       = o;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [31:0] eo,
                            input logic ez, input logic ev);
    check({name, "_aluout"}, bus.aluout, eo);
    check({name, "_zero"}, {31'd0, bus.zero}, {31'd0, ez});
    check({name, "_valid"}, {31'd0, bus.out_valid}, {31'd0, ev});
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.op       = 2'd0;

    apply(1'b1, 1'b0, 32'd0, 32'd0, ALU_ADD);
    apply(1'b1, 1'b0, 32'd0, 32'd0, ALU_ADD);
    expect_out("reset", 32'd0, 1'b1, 1'b0);

    apply(1'b0, 1'b1, 32'd1, 32'd1, ALU_SUB);
    expect_out("sub_equal", 32'd0, 1'b1, 1'b1);

    apply(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, ALU_ADD);
    expect_out("add_wrap", 32'd0, 1'b1, 1'b1);

    apply(1'b0, 1'b1, 32'd5, 32'd7, ALU_ADD);
    expect_out("add_5_7", 32'd12, 1'b0, 1'b1);

    apply(1'b0, 1'b1, 32'd0, 32'd1, ALU_SUB);
    expect_out("sub_neg", 32'hFFFF_FFFF, 1'b0, 1'b1);

    apply(1'b0, 1'b1, 32'h0000_00F0, 32'h0000_0F0F, ALU_OR);
    expect_out("or", 32'h0000_0FFF, 1'b0, 1'b1);

    apply(1'b0, 1'b1, 32'h0000_DEAD, 32'hABCD_1234, ALU_LUI);
    expect_out("lui", 32'h1234_0000, 1'b0, 1'b1);

    apply(1'b0, 1'b0, 32'd5, 32'd5, ALU_SUB);
    expect_out("hold", 32'h1234_0000, 1'b0, 1'b0);

    apply(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_0000, ALU_LUI);
    expect_out("lui_upper_ignored", 32'd0, 1'b1, 1'b1);

    apply(1'b0, 1'b1, 32'd9, 32'd4, ALU_SUB);
    expect_out("sub_pos", 32'd5, 1'b0, 1'b1);

    apply(1'b1, 1'b1, 32'd5, 32'd7, ALU_ADD);
    expect_out("reset_priority", 32'd0, 1'b1, 1'b0);

    apply(1'b0, 1'b1, 32'd0, 32'd0, ALU_OR);
    expect_out("or_zero", 32'd0, 1'b1, 1'b1);

    for (int i = 0; i < 10000; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd1;
      apply(($urandom_range(0, 199) == 0), ($urandom_range(0, 5) != 0),
            ra, rb, 2'($urandom_range(0, 3)));
    end

    apply(1'b0, 1'b0, 32'd0, 32'd0, ALU_ADD);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
